// File: rtl/axis_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_packer
// Description : AXI-Stream frame transmitter. Accepts one parallel block
//               (256-bit key, 64-bit nonce, 64-bit counter, 512-bit payload)
//               and serializes it MSB-first as 32-bit words with full
//               valid/ready backpressure. Decrypt frames (28 words) carry the
//               key/nonce/counter header ahead of the payload; encrypt frames
//               (16 words) carry the payload only.
// Ports       : axis_clk, axis_reset_n (sync, active-low)
//               load_*  : block load handshake (load_ready combinational)
//               m_axis_*: 32-bit master stream, registered outputs
//               busy, frame_count : status
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_packer #(
    parameter int GAP_CYCLES = 0
) (
    input  logic         axis_clk,
    input  logic         axis_reset_n,
    input  logic         encryp_decryp,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [255:0] load_key,
    input  logic [63:0]  load_nonce,
    input  logic [63:0]  load_counter,
    input  logic [511:0] load_data,
    output logic         m_axis_valid,
    output logic [31:0]  m_axis_data,
    output logic         m_axis_last,
    input  logic         m_axis_ready,
    output logic         busy,
    output logic [15:0]  frame_count
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SEND     = 2'd1;
    localparam logic [1:0] c_GAP      = 2'd2;

    localparam logic [4:0] c_LAST_DEC = 5'd27;
    localparam logic [4:0] c_LAST_ENC = 5'd15;

    localparam bit         c_HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [7:0] c_GAP_LAST = 8'(GAP_CYCLES - 1);

    logic [1:0]   state_q, state_d;
    logic [895:0] sr_q, sr_d;
    logic         fmt_q, fmt_d;
    logic [4:0]   idx_q, idx_d;
    logic [7:0]   gap_q, gap_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic [15:0]  frame_count_q, frame_count_d;

    logic         w_accept;
    logic         w_hs;
    logic [4:0]   w_idx_last;

    assign load_ready   = (state_q == c_IDLE) & axis_reset_n;
    assign w_accept     = load_valid & load_ready;
    assign w_hs         = valid_q & m_axis_ready;
    assign w_idx_last   = fmt_q ? c_LAST_DEC : c_LAST_ENC;

    // The current word is always the top of the shift register, so the data
    // output is registered without a separate holding flop.
    assign m_axis_valid = valid_q;
    assign m_axis_data  = sr_q[895:864];
    assign m_axis_last  = last_q;
    assign busy         = (state_q != c_IDLE);
    assign frame_count  = frame_count_q;

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        fmt_d         = fmt_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        valid_d       = valid_q;
        last_d        = last_q;
        frame_count_d = frame_count_q;

        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    fmt_d   = encryp_decryp;
                    // Encrypt frames left-align the payload so both formats
                    // drain from the same end of the register.
                    sr_d    = encryp_decryp
                              ? {load_key, load_nonce, load_counter, load_data}
                              : {load_data, 384'd0};
                    idx_d   = 5'd0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = c_SEND;
                end
            end
            c_SEND: begin
                if (w_hs) begin
                    if (idx_q == w_idx_last) begin
                        // No shift on the final word: data holds its last value.
                        valid_d       = 1'b0;
                        last_d        = 1'b0;
                        idx_d         = 5'd0;
                        gap_d         = 8'd0;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = c_HAS_GAP ? c_GAP : c_IDLE;
                    end else begin
                        sr_d   = {sr_q[863:0], 32'd0};
                        idx_d  = idx_q + 5'd1;
                        last_d = ((idx_q + 5'd1) == w_idx_last);
                    end
                end
            end
            c_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    gap_d   = 8'd0;
                    state_d = c_IDLE;
                end else begin
                    gap_d   = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_reset_n) begin
            state_q       <= c_IDLE;
            sr_q          <= '0;
            fmt_q         <= 1'b0;
            idx_q         <= 5'd0;
            gap_q         <= 8'd0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            fmt_q         <= fmt_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            valid_q       <= valid_d;
            last_q        <= last_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_packer
// Description : Self-checking bench for axis_frame_packer. Builds the expected
//               word list per frame from the field layout, drives randomized
//               payloads and ready patterns, and checks words, last, valid,
//               busy, load_ready timing, gap length and frame_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_packer;

    localparam int G = 3;

    logic         clk = 1'b0;
    logic         axis_reset_n;
    logic         encryp_decryp;
    logic         load_valid;
    logic         load_ready;
    logic [255:0] load_key;
    logic [63:0]  load_nonce;
    logic [63:0]  load_counter;
    logic [511:0] load_data;
    logic         m_axis_valid;
    logic [31:0]  m_axis_data;
    logic         m_axis_last;
    logic         m_axis_ready;
    logic         busy;
    logic [15:0]  frame_count;

    int           total = 0;
    int           bad   = 0;
    logic [15:0]  exp_fc = 16'd0;
    logic [31:0]  exp_q[$];

    always #5 clk = ~clk;

    axis_frame_packer #(.GAP_CYCLES(G)) dut (
        .axis_clk      (clk),
        .axis_reset_n  (axis_reset_n),
        .encryp_decryp (encryp_decryp),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_key      (load_key),
        .load_nonce    (load_nonce),
        .load_counter  (load_counter),
        .load_data     (load_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_data   (m_axis_data),
        .m_axis_last   (m_axis_last),
        .m_axis_ready  (m_axis_ready),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Expected stream: header fields (decrypt only) then payload, each field
    // cut into 32-bit words from its most significant end.
    task automatic build_exp(input bit dec, input logic [255:0] k, input logic [63:0] n,
                             input logic [63:0] c, input logic [511:0] d);
        exp_q.delete();
        if (dec) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(k[255-32*i -: 32]);
            exp_q.push_back(n[63:32]);
            exp_q.push_back(n[31:0]);
            exp_q.push_back(c[63:32]);
            exp_q.push_back(c[31:0]);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(d[511-32*i -: 32]);
    endtask

    // Called at a negedge with load_ready expected high. Returns at a negedge
    // with load_ready high (or after reset release when abort_at >= 0).
    // rmode: 0 = ready always, 1 = 1,0,0,1 pattern, 2 = random.
    task automatic run_frame(input bit dec, input logic [255:0] k, input logic [63:0] n,
                             input logic [63:0] c, input logic [511:0] d,
                             input int rmode, input int abort_at,
                             output logic [31:0] first_w, output logic [31:0] last_w);
        int          idx, cyc, phase, nw, g;
        bit          r, stalled;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [511:0] junk;
        first_w = '0;
        last_w  = '0;
        build_exp(dec, k, n, c, d);
        nw = exp_q.size();
        chk("load_ready_idle", load_ready, 1);
        encryp_decryp = dec;
        load_key      = k;
        load_nonce    = n;
        load_counter  = c;
        load_data     = d;
        load_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Inputs changing after the accept must not affect the frame.
        junk          = rnd512();
        encryp_decryp = ~dec;
        load_key      = junk[255:0];
        load_data     = ~junk;
        load_nonce    = junk[63:0];
        load_counter  = junk[127:64];
        idx = 0; cyc = 0; phase = 0; stalled = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        while (idx < nw) begin
            chk("valid_in_frame", m_axis_valid, 1);
            chk("busy_in_frame", busy, 1);
            chk("load_ready_in_frame", load_ready, 0);
            chk($sformatf("data_w%0d", idx), m_axis_data, exp_q[idx]);
            chk($sformatf("last_w%0d", idx), m_axis_last, (idx == nw - 1));
            if (stalled) begin
                chk("stall_data_stable", m_axis_data, prev_data);
                chk("stall_last_stable", m_axis_last, prev_last);
            end
            if (idx == abort_at) begin
                axis_reset_n = 1'b0;
                load_valid   = 1'b0;
                @(posedge clk);
                @(negedge clk);
                exp_fc = 16'd0;
                chk("rst_valid", m_axis_valid, 0);
                chk("rst_last", m_axis_last, 0);
                chk("rst_data", m_axis_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_count", frame_count, exp_fc);
                chk("rst_load_ready", load_ready, 0);
                axis_reset_n = 1'b1;
                @(posedge clk);
                @(negedge clk);
                return;
            end
            case (rmode)
                0:       r = 1'b1;
                1:       r = (phase % 4 == 0) || (phase % 4 == 3);
                default: r = ($urandom % 2 == 1) || (cyc > 200);
            endcase
            phase++;
            m_axis_ready = r;
            load_valid   = ($urandom % 2 == 1);
            if (idx == 0)      first_w = m_axis_data;
            if (idx == nw - 1) last_w  = m_axis_data;
            prev_data = m_axis_data;
            prev_last = m_axis_last;
            stalled   = !r;
            if (r) idx++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                chk("frame_timeout", 1, 0);
                return;
            end
        end
        exp_fc       = exp_fc + 16'd1;
        m_axis_ready = ($urandom % 2 == 1);
        chk("valid_after", m_axis_valid, 0);
        chk("last_after", m_axis_last, 0);
        chk("data_hold_after", m_axis_data, exp_q[nw-1]);
        chk("frame_count", frame_count, exp_fc);
        // load_ready must reappear exactly G+1 cycles after the last handshake,
        // even with load_valid held high throughout the gap.
        g = 1;
        while (!load_ready && g <= G + 4) begin
            chk("busy_in_gap", busy, 1);
            load_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            g++;
        end
        load_valid = 1'b0;
        chk("gap_len", g, G + 1);
    endtask

    initial begin
        logic [255:0] k;
        logic [511:0] d, r;
        logic [31:0]  fw, lw;
        axis_reset_n  = 1'b0;
        encryp_decryp = 1'b0;
        load_valid    = 1'b0;
        load_key      = '0;
        load_nonce    = '0;
        load_counter  = '0;
        load_data     = '0;
        m_axis_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", m_axis_valid, 0);
        chk("reset_last", m_axis_last, 0);
        chk("reset_data", m_axis_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_count", frame_count, 0);
        chk("reset_load_ready", load_ready, 0);
        axis_reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of an encrypt frame, at word 5.
        r = rnd512();
        run_frame(1'b0, r[255:0], r[319:256], r[383:320], ~r, 0, 4, fw, lw);

        // Encrypt reference pattern: word i = {2i+1, 2i+2}.
        for (int i = 0; i < 16; i++) d[511-32*i -: 32] = {16'(2*i+1), 16'(2*i+2)};
        run_frame(1'b0, '1, '1, '1, d, 0, -1, fw, lw);
        chk("enc_first_word", fw, 32'h0001_0002);
        chk("enc_last_word", lw, 32'h001F_0020);

        // Decrypt reference pattern.
        for (int b = 0; b < 32; b++) k[255-8*b -: 8] = 8'(b);
        run_frame(1'b1, k, 64'hA5A5_0000_0000_0001, 64'h0000_0000_0000_0007, '1, 0, -1, fw, lw);
        chk("dec_first_word", fw, 32'h0001_0203);
        chk("dec_last_word", lw, 32'hFFFF_FFFF);

        // Decrypt under a 1,0,0,1 ready pattern.
        r = rnd512();
        d = rnd512();
        run_frame(1'b1, r[255:0], r[319:256], r[383:320], d, 1, -1, fw, lw);

        // Random formats, fields and backpressure.
        for (int t = 0; t < 8; t++) begin
            r = rnd512();
            d = rnd512();
            run_frame(($urandom % 2 == 1), r[255:0], r[319:256], r[383:320], d, 2, -1, fw, lw);
        end

        // Counter wrap: preset near the top, then complete two frames.
        force dut.frame_count_q = 16'hFFFE;
        #1;
        release dut.frame_count_q;
        exp_fc = 16'hFFFE;
        @(negedge clk);
        chk("preset_frame_count", frame_count, exp_fc);
        for (int t = 0; t < 2; t++) begin
            r = rnd512();
            d = rnd512();
            run_frame(1'b0, r[255:0], r[319:256], r[383:320], d, 2, -1, fw, lw);
        end
        chk("wrap_frame_count", frame_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
